// File: rtl/directory_data_store.sv
// directory_data_store: per-set directory state array (8 ways x CL_SIZE bits) with
// a one-cycle registered read port, an independent writeback port and writeback-to-read bypass.
// Optional simulation trace of writes and bypasses: define DIRECTORY_DATA_STORE_TRACE_EN.
module directory_data_store #(
    parameter  int CL_SIZE = 4,
    parameter  int IDX_CNT = 512,
    localparam int IDX_ROW = $clog2(IDX_CNT),
    localparam int W       = CL_SIZE * 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         operation,
    input  logic [IDX_ROW-1:0] idx,
    input  logic [W-1:0]       cl_in_wb,
    input  logic [IDX_ROW-1:0] idx_in_wb,
    input  logic               alloc,
    input  logic               st_fwd,
    output logic [W-1:0]       cl_lines_out
);
    logic [W-1:0]       r_mem [IDX_CNT];
    logic [IDX_CNT-1:0] r_valid;
    logic [W-1:0]       r_out;
    logic               w_rd;
    logic               w_byp;
    logic [W-1:0]       w_rd_data;

    assign w_rd         = |operation;
    assign w_byp        = alloc && (st_fwd || idx == idx_in_wb);
    assign w_rd_data    = w_byp ? cl_in_wb : (r_valid[idx] ? r_mem[idx] : '0);
    assign cl_lines_out = r_out;

    // array data is not reset; gating on rst drops any write presented while in reset
    always_ff @(posedge clk) begin
        if (rst && alloc)
            r_mem[idx_in_wb] <= cl_in_wb;
    end

    // valid bits mask stale array data so reads of never-written sets return zeros
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_valid <= '0;
        else if (alloc)
            r_valid[idx_in_wb] <= 1'b1;
    end

    // registered read data; holds when no read is requested
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_out <= '0;
        else if (w_rd)
            r_out <= w_rd_data;
    end

`ifdef DIRECTORY_DATA_STORE_TRACE_EN
    // simulation-only trace of accepted writes and bypass events
    always @(posedge clk) begin
        if (rst && alloc) begin
            $write("%0t directory_data_store write idx=%h data=", $time, idx_in_wb);
            for (int i = 7; i >= 0; i--)
                $write(" %h", cl_in_wb[CL_SIZE*i +: CL_SIZE]);
            $write("\n");
        end
        if (rst && w_rd && w_byp)
            $display("%0t directory_data_store bypass idx=%h data=%h", $time, idx, cl_in_wb);
    end
`endif
endmodule

// File: tb/tb_directory_data_store.sv
// tb_directory_data_store: directed plus randomized checks of directory_data_store using
// a reference model feeding an expected-value queue.
module tb_directory_data_store;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  operation;
    logic [8:0]  idx;
    logic [31:0] cl_in_wb;
    logic [8:0]  idx_in_wb;
    logic        alloc;
    logic        st_fwd;
    logic [31:0] cl_lines_out;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_mem [int];
    logic        m_val [int];
    logic [31:0] m_out;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    directory_data_store dut (
        .clk          (clk),
        .rst          (rst),
        .operation    (operation),
        .idx          (idx),
        .cl_in_wb     (cl_in_wb),
        .idx_in_wb    (idx_in_wb),
        .alloc        (alloc),
        .st_fwd       (st_fwd),
        .cl_lines_out (cl_lines_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one cycle; reference model computes the expected output and queues it
    task automatic cyc(input logic [2:0] op, input logic [8:0] ri, input logic a,
                       input logic [8:0] wi, input logic [31:0] wd, input logic sf,
                       input string tag);
        operation = op; idx = ri; alloc = a; idx_in_wb = wi; cl_in_wb = wd; st_fwd = sf;
        if (op != 3'd0)
            m_out = (a && (sf || ri == wi)) ? wd :
                    ((m_val.exists(int'(ri)) && m_val[int'(ri)]) ? m_mem[int'(ri)] : 32'h0);
        if (a) begin
            m_mem[int'(wi)] = wd;
            m_val[int'(wi)] = 1'b1;
        end
        exp_q.push_back(m_out);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        chk(tag_q.pop_front(), cl_lines_out, exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b0; operation = '0; idx = '0; alloc = 1'b0; idx_in_wb = '0;
        cl_in_wb = '0; st_fwd = 1'b0; m_out = '0;
        #1 chk("reset_out_initial", cl_lines_out, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        cyc(3'd1, 9'h005, 1'b0, 9'h000, 32'h0, 1'b0, "rd_unwritten_005");
        chk("rd_unwritten_005_lit", cl_lines_out, 32'h00000000);
        cyc(3'd0, 9'h000, 1'b1, 9'h010, 32'h12345678, 1'b0, "wr_010");
        cyc(3'd0, 9'h000, 1'b0, 9'h000, 32'h0, 1'b0, "idle");
        cyc(3'd2, 9'h010, 1'b0, 9'h000, 32'h0, 1'b0, "rd_010");
        chk("rd_010_lit", cl_lines_out, 32'h12345678);
        cyc(3'd0, 9'h0AA, 1'b0, 9'h000, 32'h0, 1'b0, "hold_op0");
        chk("hold_op0_lit", cl_lines_out, 32'h12345678);
        cyc(3'd3, 9'h010, 1'b1, 9'h010, 32'hAAAA5555, 1'b1, "byp_stfwd_010");
        chk("byp_stfwd_010_lit", cl_lines_out, 32'hAAAA5555);
        cyc(3'd1, 9'h010, 1'b0, 9'h000, 32'h0, 1'b0, "rd_010_after_byp");
        chk("rd_010_after_byp_lit", cl_lines_out, 32'hAAAA5555);
        cyc(3'd0, 9'h000, 1'b1, 9'h020, 32'h0000000F, 1'b0, "wr_020");
        cyc(3'd4, 9'h020, 1'b0, 9'h020, 32'hDEADBEEF, 1'b1, "stfwd_no_alloc");
        chk("stfwd_no_alloc_lit", cl_lines_out, 32'h0000000F);
        cyc(3'd1, 9'h040, 1'b1, 9'h040, 32'hCAFE0001, 1'b0, "byp_idx_match");
        chk("byp_idx_match_lit", cl_lines_out, 32'hCAFE0001);
        cyc(3'd1, 9'h010, 1'b1, 9'h050, 32'h5050A0A0, 1'b0, "rd_wr_diff_idx");
        chk("rd_wr_diff_idx_lit", cl_lines_out, 32'hAAAA5555);
        cyc(3'd1, 9'h050, 1'b0, 9'h000, 32'h0, 1'b0, "rd_050");
        chk("rd_050_lit", cl_lines_out, 32'h5050A0A0);
        cyc(3'd7, 9'h020, 1'b1, 9'h060, 32'h11112222, 1'b1, "byp_stfwd_other_idx");
        chk("byp_stfwd_other_idx_lit", cl_lines_out, 32'h11112222);
        cyc(3'd1, 9'h020, 1'b0, 9'h000, 32'h0, 1'b0, "rd_020_unchanged");
        cyc(3'd1, 9'h060, 1'b0, 9'h000, 32'h0, 1'b0, "rd_060");
        cyc(3'd0, 9'h000, 1'b1, 9'h030, 32'h77778888, 1'b0, "wr_030");
        cyc(3'd1, 9'h030, 1'b0, 9'h000, 32'h0, 1'b0, "rd_030");

        // write to 0x1FF presented, then reset asserted mid-cycle before the edge
        alloc = 1'b1; idx_in_wb = 9'h1FF; cl_in_wb = 32'h0F0F0F0F; operation = 3'd0;
        #2 rst = 1'b0;
        #1 chk("async_reset_out", cl_lines_out, 32'h0);
        m_val.delete();
        m_out = '0;
        @(posedge clk);
        #1 chk("reset_held_out", cl_lines_out, 32'h0);
        @(negedge clk);
        alloc = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(3'd1, 9'h1FF, 1'b0, 9'h000, 32'h0, 1'b0, "rd_1FF_after_reset");
        chk("rd_1FF_after_reset_lit", cl_lines_out, 32'h00000000);
        cyc(3'd1, 9'h030, 1'b0, 9'h000, 32'h0, 1'b0, "rd_030_after_reset");
        chk("rd_030_after_reset_lit", cl_lines_out, 32'h00000000);

        for (int i = 0; i < 60; i++)
            cyc(3'($urandom_range(0, 7)), 9'(9'h100 + $urandom_range(0, 5)),
                1'($urandom_range(0, 1)), 9'(9'h100 + $urandom_range(0, 5)),
                32'($urandom), 1'($urandom_range(0, 3) == 0), "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
